led_fill_pattern_gen: RTL and testbench

- Parametrised successor to the team's 8-LED progressive-fill ("sang dan") drivers.
- Drives WIDTH LEDs with symmetric fill patterns:
  - centre-out or outside-in geometry;
  - fill-only (wrap) or fill-then-drain (bounce) sequencing.
- Built-in step prescaler and start/stop control.
- Sits between the board clock and the LED bank; a single instance replaces the fixed-width TSP/PST variants.

---
 rtl/led_pkg.sv | 23 ++
 rtl/step_tick_gen.sv | 34 +++
 rtl/led_fill_pattern_gen.sv | 119 +++++++++++
 tb/tb_led_fill_pattern_gen.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/led_pkg.sv
// Shared constants, state encoding and sizing helper for the LED fill pattern blocks.
package led_pkg;

  localparam int GEOM_BIT = 0;
  localparam int SEQ_BIT  = 1;

  typedef enum logic {
    FILL  = 1'b0,
    DRAIN = 1'b1
  } state_t;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'sd1 << i) < value) begin
        result = i + 1;
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/step_tick_gen.sv
// Programmable step prescaler: one tick every DIV+1 enabled cycles, cleared on CLR.
module step_tick_gen #(
  parameter int DIV_W = 24
) (
  input  logic             Clk,
  input  logic             RST,
  input  logic             EN,
  input  logic             CLR,
  input  logic [DIV_W-1:0] DIV,
  output logic             tick
);

  logic [DIV_W-1:0] cnt_r;
  logic             hit_s;

  assign hit_s = (cnt_r == DIV);
  assign tick  = EN & ~CLR & hit_s;

  // Prescaler count: a lowered DIV simply lets the count run through all-ones and wrap.
  always_ff @(posedge Clk or posedge RST) begin
    if (RST) begin
      cnt_r <= {DIV_W{1'b0}};
    end else if (CLR) begin
      cnt_r <= {DIV_W{1'b0}};
    end else if (EN && hit_s) begin
      cnt_r <= {DIV_W{1'b0}};
    end else if (EN) begin
      cnt_r <= cnt_r + DIV_W'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

endmodule

// File: rtl/led_fill_pattern_gen.sv
// Symmetric progressive-fill LED driver: centre-out / outside-in, wrap or bounce sequencing.
module led_fill_pattern_gen
  import led_pkg::*;
#(
  parameter  int WIDTH = 8,
  parameter  int DIV_W = 24,
  localparam int H     = WIDTH / 2,
  localparam int LW    = clog2(H + 1)
) (
  input  logic             Clk,
  input  logic             RST,
  input  logic             SS,
  input  logic [1:0]       MODE,
  input  logic [DIV_W-1:0] DIV,
  output logic [WIDTH-1:0] LED,
  output logic [LW-1:0]    LEVEL,
  output logic             CYCLE_DONE
);

  localparam logic [LW-1:0] H_L = LW'(H);

  logic [1:0]       active_mode_r, mode_n_s;
  state_t           state_r, state_n_s;
  logic [LW-1:0]    level_r, level_n_s;
  logic             done_r, done_n_s;
  logic [WIDTH-1:0] led_r, mask_s;
  logic             restart_s, tick_s;

  assign restart_s = SS & (MODE != active_mode_r);

  step_tick_gen #(.DIV_W(DIV_W)) u_tick (
    .Clk  (Clk),
    .RST  (RST),
    .EN   (SS),
    .CLR  (restart_s),
    .DIV  (DIV),
    .tick (tick_s)
  );

  // Next-state logic: restart outranks a tick; out-of-range levels fall back to an empty FILL.
  always_comb begin
    mode_n_s  = active_mode_r;
    state_n_s = state_r;
    level_n_s = level_r;
    done_n_s  = 1'b0;
    if (restart_s) begin
      mode_n_s  = MODE;
      state_n_s = FILL;
      level_n_s = {LW{1'b0}};
    end else if (tick_s) begin
      case (state_r)
        FILL: begin
          if (level_r < H_L) begin
            level_n_s = level_r + LW'(1);
          end else if (level_r == H_L) begin
            if (active_mode_r[SEQ_BIT]) begin
              level_n_s = H_L - LW'(1);
              state_n_s = DRAIN;
            end else begin
              level_n_s = LW'(1);
              done_n_s  = 1'b1;
            end
          end else begin
            level_n_s = {LW{1'b0}};
            state_n_s = FILL;
          end
        end
        DRAIN: begin
          if (level_r == {LW{1'b0}}) begin
            level_n_s = LW'(1);
            state_n_s = FILL;
            done_n_s  = 1'b1;
          end else if (level_r <= H_L) begin
            level_n_s = level_r - LW'(1);
          end else begin
            level_n_s = {LW{1'b0}};
            state_n_s = FILL;
          end
        end
        default: begin
          level_n_s = {LW{1'b0}};
          state_n_s = FILL;
        end
      endcase
    end else begin
      level_n_s = level_r;
    end
  end

  // Each LED lights once the level exceeds its distance from the filling edge.
  for (genvar i = 0; i < WIDTH; i++) begin : g_mask
    localparam int D_OUT = (i < H) ? i : (WIDTH - 1 - i);
    localparam int D_CEN = (i < H) ? (H - 1 - i) : (i - H);
    assign mask_s[i] = mode_n_s[GEOM_BIT] ? (level_n_s > LW'(D_OUT))
                                          : (level_n_s > LW'(D_CEN));
  end

  // State, level, mode and output registers; LED is registered alongside LEVEL.
  always_ff @(posedge Clk or posedge RST) begin
    if (RST) begin
      active_mode_r <= 2'b00;
      state_r       <= FILL;
      level_r       <= {LW{1'b0}};
      done_r        <= 1'b0;
      led_r         <= {WIDTH{1'b0}};
    end else begin
      active_mode_r <= mode_n_s;
      state_r       <= state_n_s;
      level_r       <= level_n_s;
      done_r        <= done_n_s;
      led_r         <= mask_s;
    end
  end

  assign LED        = led_r;
  assign LEVEL      = level_r;
  assign CYCLE_DONE = done_r;

endmodule

// File: tb/tb_led_fill_pattern_gen.sv
// Self-checking bench: 8- and 16-LED instances against a level-walk model plus literal sequences.
module tb_led_fill_pattern_gen;

  logic        Clk = 1'b0;
  logic        RST;
  logic        ss8, ss16;
  logic [1:0]  mode8, mode16;
  logic [23:0] div8, div16;
  logic [7:0]  led8;
  logic [2:0]  lvl8;
  logic        done8;
  logic [15:0] led16;
  logic [3:0]  lvl16;
  logic        done16;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 Clk = ~Clk;

  led_fill_pattern_gen #(.WIDTH(8), .DIV_W(24)) dut8 (
    .Clk(Clk), .RST(RST), .SS(ss8), .MODE(mode8), .DIV(div8),
    .LED(led8), .LEVEL(lvl8), .CYCLE_DONE(done8)
  );

  led_fill_pattern_gen #(.WIDTH(16), .DIV_W(24)) dut16 (
    .Clk(Clk), .RST(RST), .SS(ss16), .MODE(mode16), .DIV(div16),
    .LED(led16), .LEVEL(lvl16), .CYCLE_DONE(done16)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: level walks up to H and either restarts at 1 (wrap) or walks back to 0 (bounce).
  int          m_lvl  [2];
  bit          m_down [2];
  logic [1:0]  m_mode [2];
  logic [23:0] m_cnt  [2];
  bit          m_done [2];

  task automatic model_next(input int h, input int lvl, input bit down, input logic [1:0] amode,
                            input logic [23:0] cnt, input bit ss, input logic [1:0] mode,
                            input logic [23:0] div, output int nlvl, output bit ndown,
                            output logic [1:0] nmode, output logic [23:0] ncnt, output bit ndone);
    nlvl = lvl; ndown = down; nmode = amode; ncnt = cnt; ndone = 1'b0;
    if (!ss) begin
      ndone = 1'b0;
    end else if (mode != amode) begin
      nmode = mode; nlvl = 0; ndown = 1'b0; ncnt = 24'd0;
    end else if (cnt != div) begin
      ncnt = cnt + 24'd1;
    end else begin
      ncnt = 24'd0;
      if (!down) begin
        if (lvl < h) nlvl = lvl + 1;
        else if (amode[1]) begin nlvl = h - 1; ndown = 1'b1; end
        else begin nlvl = 1; ndone = 1'b1; end
      end else if (lvl > 0) begin
        nlvl = lvl - 1;
      end else begin
        nlvl = 1; ndown = 1'b0; ndone = 1'b1;
      end
    end
  endtask

  function automatic logic [15:0] exp_led(input int w, input int l, input bit outside);
    int ones, v;
    ones = (32'sd1 << l) - 32'sd1;
    if (outside) v = ones | (ones << (w - l));
    else         v = ((32'sd1 << (2 * l)) - 32'sd1) << (w / 2 - l);
    v = v & ((32'sd1 << w) - 32'sd1);
    return v[15:0];
  endfunction

  always @(posedge Clk or posedge RST) begin
    int nl; bit nd; logic [1:0] nm; logic [23:0] nc; bit ndn;
    if (RST) begin
      for (int k = 0; k < 2; k++) begin
        m_lvl[k] <= 0; m_down[k] <= 1'b0; m_mode[k] <= 2'b00; m_cnt[k] <= 24'd0; m_done[k] <= 1'b0;
      end
    end else begin
      model_next(4, m_lvl[0], m_down[0], m_mode[0], m_cnt[0], ss8, mode8, div8, nl, nd, nm, nc, ndn);
      m_lvl[0] <= nl; m_down[0] <= nd; m_mode[0] <= nm; m_cnt[0] <= nc; m_done[0] <= ndn;
      model_next(8, m_lvl[1], m_down[1], m_mode[1], m_cnt[1], ss16, mode16, div16, nl, nd, nm, nc, ndn);
      m_lvl[1] <= nl; m_down[1] <= nd; m_mode[1] <= nm; m_cnt[1] <= nc; m_done[1] <= ndn;
    end
  end

  // Every-cycle comparison of both instances against the model.
  always @(negedge Clk) begin
    logic [15:0] e8, e16;
    if (!RST) begin
      e8  = exp_led(8, m_lvl[0], m_mode[0][0]);
      e16 = exp_led(16, m_lvl[1], m_mode[1][0]);
      chk("model8 LED", {24'd0, led8}, {24'd0, e8[7:0]});
      chk("model8 LEVEL", {29'd0, lvl8}, m_lvl[0]);
      chk("model8 DONE", {31'd0, done8}, {31'd0, m_done[0]});
      chk("model16 LED", {16'd0, led16}, {16'd0, e16});
      chk("model16 LEVEL", {28'd0, lvl16}, m_lvl[1]);
      chk("model16 DONE", {31'd0, done16}, {31'd0, m_done[1]});
    end
  end

  task automatic wait_led8(input logic [7:0] v, input int budget);
    int n;
    n = 0;
    while (led8 !== v && n < budget) begin
      @(negedge Clk);
      n++;
    end
    chk("wait led8", {24'd0, led8}, {24'd0, v});
  endtask

  task automatic cycles_to_change(output int n);
    logic [7:0] old;
    old = led8;
    n = 0;
    do begin
      @(negedge Clk);
      n++;
    end while (led8 === old && n < 50);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] seq1 [6];
    logic [7:0] seq2 [9];
    int n, dones;
    seq1 = '{8'h81, 8'hC3, 8'hE7, 8'hFF, 8'h81, 8'hC3};
    seq2 = '{8'h18, 8'h3C, 8'h7E, 8'hFF, 8'h7E, 8'h3C, 8'h18, 8'h00, 8'h18};

    RST = 1'b1; ss8 = 1'b0; ss16 = 1'b0; mode8 = 2'b00; mode16 = 2'b00; div8 = 24'd0; div16 = 24'd0;
    repeat (2) @(negedge Clk);
    chk("reset LED8", {24'd0, led8}, 32'h0);
    chk("reset LEVEL8", {29'd0, lvl8}, 32'h0);
    chk("reset DONE8", {31'd0, done8}, 32'h0);
    chk("reset LED16", {16'd0, led16}, 32'h0);
    RST = 1'b0;
    @(negedge Clk);

    // Outside-in wrap fill
    ss8 = 1'b1; mode8 = 2'b01;
    @(negedge Clk);
    chk("t1 restart", {24'd0, led8}, 32'h0);
    for (int i = 0; i < 6; i++) begin
      @(negedge Clk);
      chk("t1 LED", {24'd0, led8}, {24'd0, seq1[i]});
      chk("t1 DONE", {31'd0, done8}, (i == 4) ? 32'd1 : 32'd0);
    end

    // Mode switch while showing E7
    @(negedge Clk);
    chk("t4 at E7", {24'd0, led8}, 32'hE7);
    mode8 = 2'b00;
    @(negedge Clk);
    chk("t4 LED", {24'd0, led8}, 32'h00);
    chk("t4 LEVEL", {29'd0, lvl8}, 32'h0);
    chk("t4 DONE", {31'd0, done8}, 32'h0);
    @(negedge Clk); chk("t4 18", {24'd0, led8}, 32'h18);
    @(negedge Clk); chk("t4 3C", {24'd0, led8}, 32'h3C);

    // Centre-out bounce
    mode8 = 2'b10;
    @(negedge Clk);
    chk("t2 restart", {24'd0, led8}, 32'h0);
    for (int i = 0; i < 9; i++) begin
      @(negedge Clk);
      chk("t2 LED", {24'd0, led8}, {24'd0, seq2[i]});
      chk("t2 DONE", {31'd0, done8}, (i == 8) ? 32'd1 : 32'd0);
    end

    // Prescaler DIV=3 with a freeze mid-step
    mode8 = 2'b00; div8 = 24'd3;
    @(negedge Clk);
    chk("t3 restart", {24'd0, led8}, 32'h0);
    cycles_to_change(n);
    chk("t3 period1", n, 32'd4);
    cycles_to_change(n);
    chk("t3 period2", n, 32'd4);
    repeat (2) @(negedge Clk);
    ss8 = 1'b0;
    repeat (10) @(negedge Clk);
    chk("t3 frozen", {24'd0, led8}, 32'h3C);
    ss8 = 1'b1;
    cycles_to_change(n);
    chk("t3 resume", n, 32'd2);
    chk("t3 resume LED", {24'd0, led8}, 32'h7E);

    // Asynchronous reset while full
    div8 = 24'd0; mode8 = 2'b01;
    wait_led8(8'hFF, 20);
    #2 RST = 1'b1;
    #1 chk("t5 async LED", {24'd0, led8}, 32'h0);
    chk("t5 async LEVEL", {29'd0, lvl8}, 32'h0);
    #1 RST = 1'b0;
    @(negedge Clk);
    chk("t5 restart", {24'd0, led8}, 32'h0);
    @(negedge Clk);
    chk("t5 first", {24'd0, led8}, 32'h81);

    // 16-LED centre-out... outside-in bounce (MODE=11)
    ss8 = 1'b0; ss16 = 1'b1; mode16 = 2'b11;
    @(negedge Clk);
    chk("t6 restart", {16'd0, led16}, 32'h0);
    dones = 0;
    for (int i = 1; i <= 34; i++) begin
      @(negedge Clk);
      if (done16 === 1'b1) dones++;
      if (i == 8)  chk("t6 full", {16'd0, led16}, 32'hFFFF);
      if (i == 8)  chk("t6 lvl8", {28'd0, lvl16}, 32'd8);
      if (i == 16) chk("t6 empty", {16'd0, led16}, 32'h0);
      if (i == 17) chk("t6 done", {31'd0, done16}, 32'd1);
    end
    chk("t6 done count", dones, 32'd2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
